// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART command-frame logic.
//   state_e      : frame parser states (HUNT, OP, LEN, PLD, CHK)
//   ERR_CHK      : err_code value for a checksum mismatch
//   ERR_TOUT     : err_code value for an inter-byte timeout
//   SYNC_DEFAULT : default frame start byte
package uart_pkg;

    typedef enum logic [2:0] {
        HUNT = 3'd0,
        OP   = 3'd1,
        LEN  = 3'd2,
        PLD  = 3'd3,
        CHK  = 3'd4
    } state_e;

    localparam logic [1:0] ERR_CHK  = 2'd1;
    localparam logic [1:0] ERR_TOUT = 2'd2;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_tmo.sv
// uart_tmo: reload / freeze / expire down-counter used as an inter-byte
// timeout. Loading sets the count to CLKS-1; each enabled, unheld cycle
// decrements it until it reaches 0, where `expired` is raised.
//   clk     : clock
//   rst     : synchronous reset, active-high (count cleared)
//   load    : reload to CLKS-1 (wins over everything else)
//   hold    : freeze the count and suppress expiry
//   en      : counter active; when low the count idles and never expires
//   expired : count is at 0 while enabled, unheld and not being reloaded
module uart_tmo #(
    parameter int unsigned CLKS = 86800,
    parameter int unsigned LEN  = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic hold,
    input  logic en,
    output logic expired
);

    localparam logic [LEN-1:0] RELOAD = LEN'(CLKS - 1);
    localparam logic [LEN-1:0] ONE    = LEN'(1);

    logic [LEN-1:0] cnt_q;
    logic [LEN-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = RELOAD;
        end else if (en && !hold && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A reload in the same cycle means a byte arrived just in time.
    assign expired = en && !hold && !load && (cnt_q == '0);

endmodule

// File: rtl/uart_cmd_ctl.sv
// uart_cmd_ctl: frames bytes from uart_rx as SYNC, OP, LEN, payload[LEN], CHK,
// streams the payload downstream with backpressure and reports completion,
// checksum errors and inter-byte timeouts.
//   clk, rst           : clock, synchronous active-high reset
//   rx_data, rx_rdy    : byte and byte-valid from uart_rx
//   rx_ack             : level acknowledge back to uart_rx
//   cmd_start          : pulse, cmd_op / cmd_len valid
//   cmd_op, cmd_len    : opcode and payload length of the current frame
//   pld_valid/data/last: payload byte stream, pld_ready from downstream
//   cmd_done           : pulse, frame ended with good checksum
//   cmd_err, err_code  : pulse on abort; code 1 = checksum, 2 = timeout
//
// state | meaning
// HUNT  | discarding bytes until SYNC
// OP    | waiting for opcode byte
// LEN   | waiting for length byte
// PLD   | receiving payload bytes (one buffered downstream at a time)
// CHK   | waiting for XOR checksum byte
module uart_cmd_ctl
    import uart_pkg::*;
#(
    parameter logic [7:0]  SYNC      = SYNC_DEFAULT,
    parameter int unsigned TOUT_CLKS = 86800,
    parameter int unsigned TOUT_LEN  = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_rdy,
    output logic       rx_ack,
    output logic       cmd_start,
    output logic [7:0] cmd_op,
    output logic [7:0] cmd_len,
    output logic       pld_valid,
    output logic [7:0] pld_data,
    output logic       pld_last,
    input  logic       pld_ready,
    output logic       cmd_done,
    output logic       cmd_err,
    output logic [1:0] err_code
);

    state_e     state_q, state_d;
    logic       ack_q, ack_d;
    logic [7:0] op_q, op_d;
    logic [7:0] len_q, len_d;
    logic       start_q, start_d;
    logic       pld_valid_q, pld_valid_d;
    logic [7:0] pld_data_q, pld_data_d;
    logic       pld_last_q, pld_last_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [1:0] err_code_q, err_code_d;
    logic [7:0] chk_q, chk_d;
    logic [7:0] remain_q, remain_d;

    logic       can_take;
    logic       accept;
    logic       tmo_hold;
    logic       tmo_en;
    logic       tmo_expired;

    // In PLD only one payload byte is buffered, so a new one waits until
    // the previous has been handed off.
    always_comb begin
        can_take = (state_q != PLD) || !pld_valid_q;
        accept   = rx_rdy && !ack_q && can_take;
    end

    // Ack stays high until rdy is seen low, so a uart_rx that misses one
    // ack cycle still clears, and the held byte is never taken twice.
    always_comb begin
        ack_d = ack_q;
        if (accept) begin
            ack_d = 1'b1;
        end else if (ack_q && !rx_rdy) begin
            ack_d = 1'b0;
        end
    end

    // Downstream stalls must never turn into a timeout.
    assign tmo_hold = pld_valid_q && !pld_ready;
    assign tmo_en   = (state_q != HUNT);

    uart_tmo #(
        .CLKS (TOUT_CLKS),
        .LEN  (TOUT_LEN)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .hold    (tmo_hold),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        len_d       = len_q;
        start_d     = 1'b0;
        pld_valid_d = pld_valid_q;
        pld_data_d  = pld_data_q;
        pld_last_d  = pld_last_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        chk_d       = chk_q;
        remain_d    = remain_q;

        if (pld_valid_q && pld_ready) begin
            pld_valid_d = 1'b0;
            pld_last_d  = 1'b0;
        end

        unique case (state_q)
            HUNT: begin
                if (accept && (rx_data == SYNC)) begin
                    state_d = OP;
                end
            end
            OP: begin
                if (accept) begin
                    op_d    = rx_data;
                    chk_d   = rx_data;
                    state_d = LEN;
                end
            end
            LEN: begin
                if (accept) begin
                    len_d    = rx_data;
                    chk_d    = chk_q ^ rx_data;
                    start_d  = 1'b1;
                    remain_d = rx_data;
                    state_d  = (rx_data == 8'd0) ? CHK : PLD;
                end
            end
            PLD: begin
                if (accept) begin
                    pld_data_d  = rx_data;
                    pld_valid_d = 1'b1;
                    pld_last_d  = (remain_q == 8'd1);
                    chk_d       = chk_q ^ rx_data;
                    remain_d    = remain_q - 8'd1;
                    if (remain_q == 8'd1) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                // A still-pending last payload byte is left alone here.
                if (accept) begin
                    if (rx_data == chk_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_CHK;
                    end
                    state_d = HUNT;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase

        if (tmo_expired) begin
            err_d       = 1'b1;
            err_code_d  = ERR_TOUT;
            state_d     = HUNT;
            pld_valid_d = 1'b0;
            pld_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            ack_q       <= 1'b0;
            op_q        <= 8'd0;
            len_q       <= 8'd0;
            start_q     <= 1'b0;
            pld_valid_q <= 1'b0;
            pld_data_q  <= 8'd0;
            pld_last_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
            chk_q       <= 8'd0;
            remain_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            op_q        <= op_d;
            len_q       <= len_d;
            start_q     <= start_d;
            pld_valid_q <= pld_valid_d;
            pld_data_q  <= pld_data_d;
            pld_last_q  <= pld_last_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            chk_q       <= chk_d;
            remain_q    <= remain_d;
        end
    end

    assign rx_ack    = ack_q;
    assign cmd_start = start_q;
    assign cmd_op    = op_q;
    assign cmd_len   = len_q;
    assign pld_valid = pld_valid_q;
    assign pld_data  = pld_data_q;
    assign pld_last  = pld_last_q;
    assign cmd_done  = done_q;
    assign cmd_err   = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_cmd_ctl.sv
module tb_uart_cmd_ctl;

    localparam int T     = 200;
    localparam int BOUND = 5 * T;

    localparam int EV_START = 0;
    localparam int EV_PLD   = 1;
    localparam int EV_DONE  = 2;
    localparam int EV_ERR   = 3;

    typedef struct {
        int         kind;
        logic [7:0] a;
        logic [7:0] b;
    } ev_t;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'd0;
    logic       rx_rdy = 1'b0;
    logic       rx_ack;
    logic       cmd_start;
    logic [7:0] cmd_op;
    logic [7:0] cmd_len;
    logic       pld_valid;
    logic [7:0] pld_data;
    logic       pld_last;
    logic       pld_ready = 1'b1;
    logic       cmd_done;
    logic       cmd_err;
    logic [1:0] err_code;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_err    = 0;
    int err_cyc  = 0;
    int ack_cyc  = 0;
    ev_t exp_q[$];

    uart_cmd_ctl #(
        .SYNC      (8'hA5),
        .TOUT_CLKS (T),
        .TOUT_LEN  (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_rdy    (rx_rdy),
        .rx_ack    (rx_ack),
        .cmd_start (cmd_start),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .pld_valid (pld_valid),
        .pld_data  (pld_data),
        .pld_last  (pld_last),
        .pld_ready (pld_ready),
        .cmd_done  (cmd_done),
        .cmd_err   (cmd_err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int k, input logic [7:0] a, input logic [7:0] b);
        ev_t e;
        e.kind = k;
        e.a    = a;
        e.b    = b;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int k, input logic [7:0] a, input logic [7:0] b);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got kind %0d a=%0h b=%0h expected none (cycle %0d)", k, a, b, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("ev_kind", k, e.kind);
            chk("ev_a", {24'd0, a}, {24'd0, e.a});
            chk("ev_b", {24'd0, b}, {24'd0, e.b});
        end
    endtask

    // Scoreboard monitor: every output event pops one expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (pld_valid && pld_ready) check_ev(EV_PLD, pld_data, {7'd0, pld_last});
            if (cmd_start) check_ev(EV_START, cmd_op, cmd_len);
            if (cmd_done) check_ev(EV_DONE, 8'd0, 8'd0);
            if (cmd_err) begin
                check_ev(EV_ERR, {6'd0, err_code}, 8'd0);
                n_err++;
                err_cyc = cyc;
            end
        end
    end

    // uart_rx model: hold the byte until ack is seen, optionally ignoring
    // the first ack cycle.
    task automatic send_byte(input logic [7:0] b, input bit ign);
        int  n;
        bit  seen_once;
        bit  done;
        @(negedge clk);
        rx_data   = b;
        rx_rdy    = 1'b1;
        n         = 0;
        seen_once = 1'b0;
        done      = 1'b0;
        while (!done && n < BOUND) begin
            @(posedge clk);
            #1;
            n++;
            if (seen_once) begin
                chk("missed_ack_hold", {31'd0, rx_ack}, 32'd1);
                rx_rdy = 1'b0;
                done   = 1'b1;
            end else if (rx_ack) begin
                ack_cyc = cyc;
                if (ign) begin
                    seen_once = 1'b1;
                end else begin
                    rx_rdy = 1'b0;
                    done   = 1'b1;
                end
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL rx_ack_wait: got no ack for byte %0h expected ack within %0d cycles", b, BOUND);
            rx_rdy = 1'b0;
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic send_seq(input bq_t s, input bit ign);
        foreach (s[i]) send_byte(s[i], ign);
    endtask

    task automatic drain(input string name);
        repeat (10) @(posedge clk);
        #1;
        chk(name, exp_q.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rx_ack"}, {31'd0, rx_ack}, 32'd0);
        chk({tag, "_start"}, {31'd0, cmd_start}, 32'd0);
        chk({tag, "_op"}, {24'd0, cmd_op}, 32'd0);
        chk({tag, "_len"}, {24'd0, cmd_len}, 32'd0);
        chk({tag, "_pvalid"}, {31'd0, pld_valid}, 32'd0);
        chk({tag, "_pdata"}, {24'd0, pld_data}, 32'd0);
        chk({tag, "_plast"}, {31'd0, pld_last}, 32'd0);
        chk({tag, "_done"}, {31'd0, cmd_done}, 32'd0);
        chk({tag, "_err"}, {31'd0, cmd_err}, 32'd0);
        chk({tag, "_code"}, {30'd0, err_code}, 32'd0);
    endtask

    initial begin
        bq_t s;
        int  e0;
        bit  got;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Good frame: checksum 10^03^11^22^33 = 13.
        expect_ev(EV_START, 8'h10, 8'h03);
        expect_ev(EV_PLD, 8'h11, 8'h00);
        expect_ev(EV_PLD, 8'h22, 8'h00);
        expect_ev(EV_PLD, 8'h33, 8'h01);
        expect_ev(EV_DONE, 8'h00, 8'h00);
        s = {8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13};
        send_seq(s, 1'b0);
        drain("good_drain");

        // Garbage then bad checksum (expected 20), then a good zero-length frame.
        expect_ev(EV_START, 8'h20, 8'h00);
        expect_ev(EV_ERR, 8'h01, 8'h00);
        s = {8'h00, 8'hFF, 8'hA5, 8'h20, 8'h00, 8'h55};
        send_seq(s, 1'b0);
        drain("badchk_drain");
        expect_ev(EV_START, 8'h20, 8'h00);
        expect_ev(EV_DONE, 8'h00, 8'h00);
        s = {8'hA5, 8'h20, 8'h00, 8'h20};
        send_seq(s, 1'b0);
        drain("zerolen_drain");
        chk("err_code_held", {30'd0, err_code}, 32'd1);

        // Timeout after one of five payload bytes.
        expect_ev(EV_START, 8'h30, 8'h05);
        expect_ev(EV_PLD, 8'h01, 8'h00);
        expect_ev(EV_ERR, 8'h02, 8'h00);
        e0 = n_err;
        s = {8'hA5, 8'h30, 8'h05, 8'h01};
        send_seq(s, 1'b0);
        got = 1'b0;
        for (int n = 0; n < T + 50 && !got; n++) begin
            @(negedge clk);
            #1;
            if (n_err != e0) got = 1'b1;
        end
        chk("tout_seen", {31'd0, got}, 32'd1);
        // rx_ack rises one cycle after acceptance, so acceptance+T+1 is ack+T.
        chk("tout_latency", err_cyc - ack_cyc, T);
        chk("tout_pvalid", {31'd0, pld_valid}, 32'd0);
        drain("tout_drain");
        chk("tout_count", n_err - e0, 1);

        // Backpressure: checksum 40^02^AA^BB = 53.
        expect_ev(EV_START, 8'h40, 8'h02);
        expect_ev(EV_PLD, 8'hAA, 8'h00);
        expect_ev(EV_PLD, 8'hBB, 8'h01);
        expect_ev(EV_DONE, 8'h00, 8'h00);
        pld_ready = 1'b0;
        s = {8'hA5, 8'h40, 8'h02, 8'hAA};
        send_seq(s, 1'b0);
        fork
            send_byte(8'hBB, 1'b0);
            begin
                repeat (3 * T) @(posedge clk);
                #1;
                chk("bp_ack_low", {31'd0, rx_ack}, 32'd0);
                chk("bp_pvalid", {31'd0, pld_valid}, 32'd1);
                chk("bp_no_err", {31'd0, cmd_err}, 32'd0);
                pld_ready = 1'b1;
            end
        join
        send_byte(8'h53, 1'b0);
        drain("bp_drain");

        // Missed ack on every byte: checksum 70^01^C3 = B2.
        expect_ev(EV_START, 8'h70, 8'h01);
        expect_ev(EV_PLD, 8'hC3, 8'h01);
        expect_ev(EV_DONE, 8'h00, 8'h00);
        s = {8'hA5, 8'h70, 8'h01, 8'hC3, 8'hB2};
        send_seq(s, 1'b1);
        drain("miss_drain");

        // Reset in PLD with a stalled payload byte.
        expect_ev(EV_START, 8'h50, 8'h02);
        pld_ready = 1'b0;
        s = {8'hA5, 8'h50, 8'h02, 8'h77};
        send_seq(s, 1'b0);
        chk("rst_pre_pvalid", {31'd0, pld_valid}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero("midrst");
        rst = 1'b0;
        pld_ready = 1'b1;
        drain("midrst_drain");

        // Good frame after reset: checksum 60^01^99 = F8.
        expect_ev(EV_START, 8'h60, 8'h01);
        expect_ev(EV_PLD, 8'h99, 8'h01);
        expect_ev(EV_DONE, 8'h00, 8'h00);
        s = {8'hA5, 8'h60, 8'h01, 8'h99, 8'hF8};
        send_seq(s, 1'b0);
        drain("post_rst_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
